// File: rtl/memory_access_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// memory_access_stage_pkg : Y86-64 icodes, status codes and M-stage FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package memory_access_stage_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

endpackage
`default_nettype wire

// File: rtl/memory_access_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// memory_access_stage_if : data-memory req/ready bus between M stage and dmem
// Rev 1.0
// ----------------------------------------------------------------------------
interface memory_access_stage_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ready;
    logic [63:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/memory_access_stage_mem_ctrl_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_ctrl_decode : icode -> read / write / address-from-valA select
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_ctrl_decode
    import memory_access_stage_pkg::*;
(
    input  logic [3:0] icode,
    output logic       rd,
    output logic       wr,
    output logic       sel_vala
);

    always_comb begin
        rd       = 1'b0;
        wr       = 1'b0;
        sel_vala = 1'b0;
        case (icode)
            IMRMOVQ: rd = 1'b1;
            IPOPQ,
            IRET: begin
                rd       = 1'b1;
                sel_vala = 1'b1;
            end
            IRMMOVQ,
            IPUSHQ,
            ICALL:   wr = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// memory_access_stage : Y86-64 M stage, one variable-latency dmem access per
// instruction; define MEM_TIMEOUT_EN to bound the wait for dmem ready. Rev 1.0
// ----------------------------------------------------------------------------
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DMEM_BYTES     = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [2:0]                    M_stat_i,
    input  logic [3:0]                    M_icode_i,
    input  logic [63:0]                   M_valE_i,
    input  logic [63:0]                   M_valA_i,
    output logic [2:0]                    m_stat_o,
    output logic [63:0]                   m_valM_o,
    output logic                          m_stall_o,
    memory_access_stage_if.master         dmem
);

    localparam logic [63:0] c_ADDR_MAX = 64'(DMEM_BYTES) - 64'd8;

    ms_state_t   r_state;
    ms_state_t   w_state_nxt;

    logic        w_rd;
    logic        w_wr;
    logic        w_sel_vala;
    logic [63:0] w_addr;
    logic        w_mem_op;
    logic        w_range_bad;
    logic        w_issue;
    logic        w_tmo_hit;
    logic        w_busy_end;

    logic        r_req;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_valm;
    logic        r_err;

    mem_ctrl_decode u_decode (
        .icode    (M_icode_i),
        .rd       (w_rd),
        .wr       (w_wr),
        .sel_vala (w_sel_vala)
    );

    assign w_addr      = w_sel_vala ? M_valA_i : M_valE_i;
    assign w_mem_op    = (w_rd || w_wr) && (M_stat_i == SAOK);
    assign w_range_bad = w_mem_op && (w_addr > c_ADDR_MAX);
    assign w_issue     = (r_state == MS_IDLE) && w_mem_op && !w_range_bad;
    assign w_busy_end  = (r_state == MS_BUSY) && (dmem.ready || w_tmo_hit);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Counts completed BUSY cycles; a ready in the last allowed cycle still wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state != MS_BUSY) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign w_tmo_hit = (r_state == MS_BUSY) && !dmem.ready &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MS_IDLE: if (w_issue)    w_state_nxt = MS_BUSY;
            MS_BUSY: if (w_busy_end) w_state_nxt = MS_DONE;
            MS_DONE:                 w_state_nxt = MS_IDLE;
            default:                 w_state_nxt = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valm  <= '0;
            r_err   <= 1'b0;
        end else if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= w_wr;
            r_addr  <= w_addr;
            r_wdata <= M_valA_i;
            r_err   <= 1'b0;
        end else if (w_busy_end) begin
            r_req <= 1'b0;
            r_err <= dmem.ready ? dmem.err : 1'b1;
            if (dmem.ready && !r_we) begin
                r_valm <= dmem.rdata;
            end
        end else if (r_state == MS_DONE) begin
            r_err <= 1'b0;
        end
    end

    assign dmem.req   = r_req;
    assign dmem.we    = r_we;
    assign dmem.addr  = r_addr;
    assign dmem.wdata = r_wdata;
    assign m_valM_o   = r_valm;

    // Stall is held off during reset so pipeline control never sees a stale request.
    assign m_stall_o = rst_n_i && w_mem_op && !w_range_bad && (r_state != MS_DONE);

    always_comb begin
        m_stat_o = M_stat_i;
        if (w_range_bad || ((r_state == MS_DONE) && r_err)) begin
            m_stat_o = SADR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_memory_access_stage : scoreboard bench with a variable-latency dmem model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    localparam int unsigned DMEM = 65536;
    localparam int unsigned TMO  = 4;

    typedef struct {
        logic [2:0]  stat;
        int          stall;
        int          reqs;
        bit          chk_mem;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          chk_valm;
        logic [63:0] valm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  M_stat = SAOK;
    logic [3:0]  M_icode = INOP;
    logic [63:0] M_valE = '0;
    logic [63:0] M_valA = '0;
    logic [2:0]  m_stat;
    logic [63:0] m_valM;
    logic        m_stall;

    memory_access_stage_if dmem_bus ();

    memory_access_stage #(
        .DMEM_BYTES     (DMEM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .M_stat_i  (M_stat),
        .M_icode_i (M_icode),
        .M_valE_i  (M_valE),
        .M_valA_i  (M_valA),
        .m_stat_o  (m_stat),
        .m_valM_o  (m_valM),
        .m_stall_o (m_stall),
        .dmem      (dmem_bus)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // dmem model state
    int          mem_wait   = 0;
    logic [63:0] mem_rdata  = '0;
    bit          mem_err    = 1'b0;
    int          busy       = 0;
    int          req_cycles = 0;
    bit          seen_we    = 1'b0;
    logic [63:0] seen_addr  = '0;
    logic [63:0] seen_wdata = '0;
    bit          stable     = 1'b1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        dmem_bus.ready = 1'b0;
        dmem_bus.rdata = '0;
        dmem_bus.err   = 1'b0;
    end

    always @(negedge clk) begin
        if (dmem_bus.req === 1'b1) begin
            if (req_cycles == 0) begin
                seen_we    = dmem_bus.we;
                seen_addr  = dmem_bus.addr;
                seen_wdata = dmem_bus.wdata;
            end else if (dmem_bus.we !== seen_we || dmem_bus.addr !== seen_addr ||
                         dmem_bus.wdata !== seen_wdata) begin
                stable = 1'b0;
            end
            req_cycles++;
            dmem_bus.ready = (busy == mem_wait);
            dmem_bus.rdata = dmem_bus.ready ? mem_rdata : {$urandom, $urandom};
            dmem_bus.err   = mem_err;
            busy++;
        end else begin
            dmem_bus.ready = 1'b0;
            dmem_bus.err   = 1'b0;
            busy           = 0;
        end
    end

    task automatic run_instr(input logic [3:0] icode, input logic [2:0] stat,
                             input logic [63:0] vale, input logic [63:0] vala,
                             input int wait_c, input logic [63:0] rdata, input bit err);
        exp_t        e;
        bit          rd, wr, memop, bad, tmo;
        logic [63:0] addr;
        int          reqs;
        int          stalls;
        rd    = (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
        wr    = (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
        addr  = ((icode == IPOPQ) || (icode == IRET)) ? vala : vale;
        memop = (rd || wr) && (stat == SAOK);
        bad   = memop && (addr > 64'(DMEM - 8));
`ifdef MEM_TIMEOUT_EN
        tmo = (wait_c >= int'(TMO));
`else
        tmo = 1'b0;
`endif
        reqs       = tmo ? int'(TMO) : wait_c + 1;
        e.chk_mem  = memop && !bad;
        e.reqs     = e.chk_mem ? reqs : 0;
        e.stall    = e.chk_mem ? reqs + 1 : 0;
        e.stat     = (bad || (e.chk_mem && (err || tmo))) ? SADR : stat;
        e.we       = wr;
        e.addr     = addr;
        e.wdata    = vala;
        e.chk_valm = e.chk_mem && rd && !tmo;
        e.valm     = rdata;

        @(negedge clk);
        mem_wait   = wait_c;
        mem_rdata  = rdata;
        mem_err    = err;
        req_cycles = 0;
        stable     = 1'b1;
        M_icode    = icode;
        M_stat     = stat;
        M_valE     = vale;
        M_valA     = vala;
        sb.push_back(e);
        #1;
        stalls = 0;
        while (m_stall === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        e = sb.pop_front();
        if (stalls >= 200) chk("stall_bound", 64'(stalls), 64'(e.stall));
        chk("stat", 64'(m_stat), 64'(e.stat));
        chk("stall_cycles", 64'(stalls), 64'(e.stall));
        chk("req_cycles", 64'(req_cycles), 64'(e.reqs));
        if (e.chk_mem) begin
            chk("we", 64'(seen_we), 64'(e.we));
            chk("addr", seen_addr, e.addr);
            chk("wdata", seen_wdata, e.wdata);
            chk("bus_stable", 64'(stable), 64'd1);
        end
        if (e.chk_valm) chk("valM", m_valM, e.valm);
        @(negedge clk);
        M_icode = INOP;
        M_stat  = SAOK;
    endtask

    initial begin
        #2;
        chk("rst_req", 64'(dmem_bus.req), 64'd0);
        chk("rst_stall", 64'(m_stall), 64'd0);
        chk("rst_valM", m_valM, 64'd0);
        chk("rst_addr", dmem_bus.addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(IMRMOVQ, SAOK, 64'h100, 64'h0, 0, 64'hDEAD, 1'b0);
        run_instr(INOP,    SAOK, 64'h0, 64'h0, 0, 64'h0, 1'b0);
        run_instr(IRMMOVQ, SAOK, 64'h200, 64'h55, 3, 64'h0, 1'b0);
        run_instr(IPOPQ,   SAOK, 64'h10, 64'(DMEM - 4), 0, 64'h0, 1'b0);
        run_instr(IMRMOVQ, SAOK, 64'(DMEM - 8), 64'h7, 1, 64'h1234_5678_9ABC_DEF0, 1'b0);
        run_instr(IRMMOVQ, SAOK, 64'(DMEM - 7), 64'h99, 0, 64'h0, 1'b0);
        run_instr(IPUSHQ,  SAOK, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 0, 64'h0, 1'b0);
        run_instr(IRET,    SAOK, 64'hFFFF_0000, 64'h400, 2, 64'hCAFE_F00D, 1'b0);
        run_instr(IMRMOVQ, SINS, 64'h100, 64'h0, 0, 64'h0, 1'b0);
        run_instr(ICALL,   SAOK, 64'h300, 64'h77, 1, 64'h0, 1'b1);
        run_instr(INOP,    SAOK, 64'h0, 64'h0, 0, 64'h0, 1'b0);
        run_instr(IOPQ,    SAOK, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 64'h0, 1'b0);
        run_instr(IPOPQ,   SAOK, 64'h0, 64'h800, 0, 64'h5A5A, 1'b0);
`ifdef MEM_TIMEOUT_EN
        run_instr(IMRMOVQ, SAOK, 64'h500, 64'h0, 1000000, 64'h0, 1'b0);
        run_instr(INOP,    SAOK, 64'h0, 64'h0, 0, 64'h0, 1'b0);
`endif

        // Reset while an access is outstanding.
        @(negedge clk);
        mem_wait  = 50;
        M_icode   = IMRMOVQ;
        M_stat    = SAOK;
        M_valE    = 64'h600;
        M_valA    = 64'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("midbusy_req", 64'(dmem_bus.req), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 64'(dmem_bus.req), 64'd0);
        chk("arst_stall", 64'(m_stall), 64'd0);
        M_icode = INOP;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_req", 64'(dmem_bus.req), 64'd0);
        chk("post_we", 64'(dmem_bus.we), 64'd0);
        chk("post_addr", dmem_bus.addr, 64'd0);
        chk("post_wdata", dmem_bus.wdata, 64'd0);
        chk("post_valM", m_valM, 64'd0);
        chk("post_stall", 64'(m_stall), 64'd0);
        chk("post_stat", 64'(m_stat), 64'(SAOK));
        run_instr(IMRMOVQ, SAOK, 64'h700, 64'h0, 0, 64'hBEEF, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
